// File: rtl/btb_update_ctrl_pkg.sv
// Shared types for the BTB write-side update controller.
package btb_update_ctrl_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        BTB_UPD_IDLE,
        BTB_UPD_LOOKUP,
        BTB_UPD_WRITE
    } btb_upd_state_t;

    typedef struct packed {
        lc3b_word pc;
        lc3b_word target;
    } btb_upd_entry_t;

    // Tree pseudo-LRU victim: lru[0] picks the pair, lru[1]/lru[2] the way within it.
    function automatic logic [1:0] plru_victim(input logic [2:0] lru);
        logic [1:0] v;
        if (!lru[0]) v = lru[1] ? 2'd1 : 2'd0;
        else         v = lru[2] ? 2'd3 : 2'd2;
        return v;
    endfunction

endpackage

// File: rtl/btb_update_ctrl_victim_sel.sv
// Way selection for a BTB update: lowest matching way on a hit, PLRU victim on a miss.
module btb_victim_sel
    import btb_update_ctrl_pkg::*;
(
    input  logic       wb_hit,
    input  logic       wb_comp0,
    input  logic       wb_comp1,
    input  logic       wb_comp2,
    input  logic       wb_comp3,
    input  logic [2:0] lru_out,
    output logic [1:0] way
);

    // Priority-encode the tag compares on a hit, otherwise decode the LRU tree.
    always_comb begin
        way = 2'd0;
        if (wb_hit) begin
            if      (wb_comp0) way = 2'd0;
            else if (wb_comp1) way = 2'd1;
            else if (wb_comp2) way = 2'd2;
            else if (wb_comp3) way = 2'd3;
        end else begin
            way = plru_victim(lru_out);
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: queues resolved taken branches and turns each
// into a lookup cycle followed by a one-hot way write plus LRU update.
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [15:0] br_pc,
    input  logic [15:0] br_target,
    output logic        br_ready,
    input  logic        wb_hit,
    input  logic        wb_comp0_out,
    input  logic        wb_comp1_out,
    input  logic        wb_comp2_out,
    input  logic        wb_comp3_out,
    input  logic [2:0]  lru_out,
    output logic        wb_enable,
    output logic [15:0] old_pc_addr,
    output logic [15:0] wb_addr,
    output logic        way0_write,
    output logic        way1_write,
    output logic        way2_write,
    output logic        way3_write,
    output logic        lru_load,
    output logic        upd_busy
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    btb_upd_entry_t q_mem [QDEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;
    logic           full;
    btb_upd_entry_t head;

    btb_upd_state_t state;
    btb_upd_state_t state_next;
    logic [1:0]     way_q;
    logic [1:0]     victim_way;
    logic           wr_active;

    assign full      = (count == CW'(QDEPTH));
    assign br_ready  = !full;
    assign push      = br_valid && br_ready && br_taken;
    assign pop       = (state == BTB_UPD_WRITE);
    assign head      = q_mem[rd_ptr];
    assign old_pc_addr = head.pc;
    assign wb_addr     = head.target;

    // Update queue: storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_mem  <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_mem[wr_ptr] <= '{pc: br_pc, target: br_target};
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    btb_victim_sel u_victim_sel (
        .wb_hit   (wb_hit),
        .wb_comp0 (wb_comp0_out),
        .wb_comp1 (wb_comp1_out),
        .wb_comp2 (wb_comp2_out),
        .wb_comp3 (wb_comp3_out),
        .lru_out  (lru_out),
        .way      (victim_way)
    );

    // FSM state register and the way captured at the end of LOOKUP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BTB_UPD_IDLE;
            way_q <= '0;
        end else begin
            state <= state_next;
            if (state == BTB_UPD_LOOKUP) begin
                way_q <= victim_way;
            end
        end
    end

    // Next-state logic; WRITE decides on the registered count, so an enqueue
    // landing in the same cycle as the last pop is picked up from IDLE.
    always_comb begin
        state_next = state;
        wb_enable  = 1'b0;
        case (state)
            BTB_UPD_IDLE: begin
                if (count != '0) state_next = BTB_UPD_LOOKUP;
            end
            BTB_UPD_LOOKUP: begin
                wb_enable  = 1'b1;
                state_next = BTB_UPD_WRITE;
            end
            BTB_UPD_WRITE: begin
                wb_enable  = 1'b1;
                state_next = (count > CW'(1)) ? BTB_UPD_LOOKUP : BTB_UPD_IDLE;
            end
            default: state_next = BTB_UPD_IDLE;
        endcase
    end

    // Write strobes are masked by rst_n so a reset cycle can never issue a write.
    assign wr_active  = (state == BTB_UPD_WRITE) && rst_n;
    assign way0_write = wr_active && (way_q == 2'd0);
    assign way1_write = wr_active && (way_q == 2'd1);
    assign way2_write = wr_active && (way_q == 2'd2);
    assign way3_write = wr_active && (way_q == 2'd3);
    assign lru_load   = wr_active;
    assign upd_busy   = wb_enable;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: stimulus pushes expected writes,
// a negedge monitor pops and compares whenever a way strobe appears.
module tb_btb_update_ctrl;

    localparam int unsigned QDEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid, br_taken;
    logic [15:0] br_pc, br_target;
    logic        br_ready;
    logic        wb_hit, wb_comp0_out, wb_comp1_out, wb_comp2_out, wb_comp3_out;
    logic [2:0]  lru_out;
    logic        wb_enable;
    logic [15:0] old_pc_addr, wb_addr;
    logic        way0_write, way1_write, way2_write, way3_write;
    logic        lru_load, upd_busy;

    btb_update_ctrl #(.QDEPTH(QDEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .br_valid     (br_valid),
        .br_taken     (br_taken),
        .br_pc        (br_pc),
        .br_target    (br_target),
        .br_ready     (br_ready),
        .wb_hit       (wb_hit),
        .wb_comp0_out (wb_comp0_out),
        .wb_comp1_out (wb_comp1_out),
        .wb_comp2_out (wb_comp2_out),
        .wb_comp3_out (wb_comp3_out),
        .lru_out      (lru_out),
        .wb_enable    (wb_enable),
        .old_pc_addr  (old_pc_addr),
        .wb_addr      (wb_addr),
        .way0_write   (way0_write),
        .way1_write   (way1_write),
        .way2_write   (way2_write),
        .way3_write   (way3_write),
        .lru_load     (lru_load),
        .upd_busy     (upd_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n_writes = 0;
    int en_cycles = 0;
    int stall_cnt = 0;
    logic [33:0] sb [$];   // {pc, target, way}
    int wr_cycles [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every way strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [3:0]  strobes;
        logic [33:0] e;
        if (rst_n) begin
            strobes = {way3_write, way2_write, way1_write, way0_write};
            check("upd_busy", {31'd0, upd_busy}, {31'd0, wb_enable});
            if (wb_enable) en_cycles++;
            if (lru_load && strobes == 4'b0000) check("lru_without_way", 32'd1, 32'd0);
            if (strobes != 4'b0000) begin
                n_writes++;
                wr_cycles.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_write", {28'd0, strobes}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("way_onehot", {28'd0, strobes}, 32'd1 << e[1:0]);
                    check("old_pc_addr", {16'd0, old_pc_addr}, {16'd0, e[33:18]});
                    check("wb_addr", {16'd0, wb_addr}, {16'd0, e[17:2]});
                    check("lru_load", {31'd0, lru_load}, 32'd1);
                    check("wb_enable_in_write", {31'd0, wb_enable}, 32'd1);
                end
            end
        end
    end

    // Present one branch, hold it while br_ready is low, return just after acceptance.
    task automatic send(input logic [15:0] pc, input logic [15:0] tgt,
                        input logic taken, input logic [1:0] way);
        int budget = 0;
        br_valid = 1'b1; br_taken = taken; br_pc = pc; br_target = tgt;
        while (!br_ready && budget < 50) begin
            stall_cnt++;
            budget++;
            @(posedge clk); #1;
        end
        if (budget >= 50) check("send_timeout", 32'd1, 32'd0);
        if (taken) sb.push_back({pc, tgt, way});
        @(posedge clk); #1;
        br_valid = 1'b0; br_taken = 1'b0;
    endtask

    task automatic wait_idle();
        int budget = 0;
        while ((sb.size() != 0 || wb_enable) && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check("drain_timeout", {31'd0, (budget >= 100)}, 32'd0);
    endtask

    task automatic set_btb(input logic hit, input logic [3:0] comp, input logic [2:0] lru);
        wb_hit = hit;
        {wb_comp3_out, wb_comp2_out, wb_comp1_out, wb_comp0_out} = comp;
        lru_out = lru;
    endtask

    initial begin
        int base, nw, en0, budget;
        rst_n = 1'b0;
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 16'h1234; br_target = 16'h5678;
        set_btb(1'b0, 4'b0000, 3'b000);

        // Reset held two cycles with a branch presented.
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_br_ready", {31'd0, br_ready}, 32'd1);
            check("rst_strobes", {28'd0, way3_write, way2_write, way1_write, way0_write}, 32'd0);
            check("rst_lru_load", {31'd0, lru_load}, 32'd0);
            check("rst_wb_enable", {31'd0, wb_enable}, 32'd0);
            check("rst_old_pc", {16'd0, old_pc_addr}, 32'd0);
            check("rst_wb_addr", {16'd0, wb_addr}, 32'd0);
        end
        br_valid = 1'b0; br_taken = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_no_write", n_writes, 32'd0);
        check("post_rst_no_lookup", en_cycles, 32'd0);

        // Miss fill into an empty BTB with explicit latency checks.
        set_btb(1'b0, 4'b0000, 3'b000);
        send(16'h3010, 16'h3100, 1'b1, 2'd0);
        check("fill_idle_after_push", {31'd0, wb_enable}, 32'd0);
        @(posedge clk); #1;
        check("fill_lookup", {31'd0, wb_enable}, 32'd1);
        check("fill_lookup_no_write", {31'd0, lru_load}, 32'd0);
        @(posedge clk); #1;
        check("fill_write_way0", {31'd0, way0_write}, 32'd1);
        wait_idle();

        // Hit update rewrites the resident way.
        set_btb(1'b1, 4'b0100, 3'b000);
        send(16'h3010, 16'h3200, 1'b1, 2'd2);
        wait_idle();

        // Lowest matching way wins on a hit.
        set_btb(1'b1, 4'b1010, 3'b111);
        send(16'h3020, 16'h3300, 1'b1, 2'd1);
        wait_idle();

        // PLRU victim decode on misses.
        set_btb(1'b0, 4'b0000, 3'b001);
        send(16'h4020, 16'h4100, 1'b1, 2'd2);
        wait_idle();
        set_btb(1'b0, 4'b0000, 3'b101);
        send(16'h4030, 16'h4200, 1'b1, 2'd3);
        wait_idle();
        set_btb(1'b0, 4'b0000, 3'b010);
        send(16'h4040, 16'h4300, 1'b1, 2'd1);
        wait_idle();

        // Backpressure: a burst long enough to fill the queue despite pops.
        set_btb(1'b0, 4'b0000, 3'b000);
        stall_cnt = 0;
        base = wr_cycles.size();
        for (int k = 0; k < QDEPTH + 3; k++) begin
            send(16'h5000 + 16'(k * 16), 16'h6000 + 16'(k * 2), 1'b1, 2'd0);
        end
        wait_idle();
        check("bp_ready_went_low", {31'd0, (stall_cnt > 0)}, 32'd1);
        check("bp_write_count", wr_cycles.size() - base, QDEPTH + 3);
        for (int k = base + 1; k < wr_cycles.size(); k++) begin
            check("bp_gap", wr_cycles[k] - wr_cycles[k-1], 32'd2);
        end

        // Not-taken branches never start a lookup.
        en0 = en_cycles;
        send(16'h7000, 16'h7100, 1'b0, 2'd0);
        repeat (5) @(posedge clk);
        #1;
        check("not_taken_no_lookup", en_cycles - en0, 32'd0);

        // Reset asserted during LOOKUP discards the update.
        send(16'h8000, 16'h8100, 1'b1, 2'd0);
        budget = 0;
        while (!wb_enable && budget < 10) begin
            @(posedge clk); #1;
            budget++;
        end
        check("midrst_reached_lookup", {31'd0, wb_enable}, 32'd1);
        nw = n_writes;
        rst_n = 1'b0;
        sb.delete();
        check("midrst_no_strobe_in_reset", {28'd0, way3_write, way2_write, way1_write, way0_write}, 32'd0);
        @(posedge clk); #1;
        check("midrst_idle", {31'd0, wb_enable}, 32'd0);
        check("midrst_br_ready", {31'd0, br_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_write", n_writes - nw, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
